// File: rtl/usb_fs_line_rx.sv
// usb_fs_line_rx
//
// Purpose:
//   USB full-speed line receiver. Takes the raw, asynchronous D+/D- pair,
//   oversampled OVERSAMPLE times per bit, and turns it into a byte stream
//   with framing strobes. It recovers the bit clock from line transitions,
//   finds SYNC, NRZI-decodes, removes stuff bits, assembles bytes LSB first
//   and detects EOP. PID/CRC checking is left to the packet layer above.
//
// Parameters:
//   OVERSAMPLE : clk cycles per USB bit, even and >= 4 (4 -> 48 MHz clk)
//   IDLE_BITS  : consecutive J bit samples needed to leave the error state
//
// Ports:
//   clk       : receive clock, OVERSAMPLE x bit rate
//   reset     : asynchronous active-high reset
//   linep     : raw D+ line, asynchronous to clk
//   linem     : raw D- line, asynchronous to clk
//   rx_data   : received byte, valid while rx_valid is high
//   rx_valid  : one-cycle strobe per received byte
//   rx_sop    : one-cycle strobe when SYNC completes
//   rx_eop    : one-cycle strobe on a clean end of packet
//   rx_err    : one-cycle strobe on a framing or bit-stuff error
//   rx_active : high from rx_sop until rx_eop or rx_err

module usb_fs_line_rx #(
  parameter int OVERSAMPLE = 4,
  parameter int IDLE_BITS  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       linep,
  input  logic       linem,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic       rx_err,
  output logic       rx_active
);

  localparam int PHASE_W = $clog2(OVERSAMPLE);
  localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(OVERSAMPLE / 2);
  localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(OVERSAMPLE - 1);
  localparam int IDLE_W = $clog2(IDLE_BITS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);

  // Line states, encoded as {D+, D-}.
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } line_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ERROR
  } state_e;

  // Synchronizer stages. They reset to J so the receiver comes out of reset
  // looking at an idle bus rather than a spurious SE0.
  line_e line_meta_q, line_meta_d;
  line_e line_sync_q, line_sync_d;

  logic [PHASE_W-1:0] phase_q, phase_d;

  state_e      state_q, state_d;
  line_e       prev_line_q, prev_line_d;
  logic [2:0]  ones_q, ones_d;
  logic [2:0]  zero_q, zero_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        err_flag_q, err_flag_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_sop_q, rx_sop_d;
  logic        rx_eop_q, rx_eop_d;
  logic        rx_err_q, rx_err_d;
  logic        rx_active_q, rx_active_d;

  logic sample;
  logic nrzi_bit;

  // Two-flop synchronizer on each line, carried as a pair so both lines
  // always resolve on the same clk edge.
  always_comb begin
    line_meta_d = line_e'({linep, linem});
    line_sync_d = line_meta_q;
  end

  // Bit-clock recovery. A pending change (meta stage differs from sync
  // stage) zeroes the phase on the same edge that the new state lands in
  // the sync stage, so the phase counts cycles since the last transition.
  // Sampling mid-way keeps a full margin against a 3 or 5 cycle bit.
  always_comb begin
    if (line_meta_q != line_sync_q) begin
      phase_d = '0;
    end else if (phase_q == PHASE_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PHASE_W'(1);
    end
  end

  assign sample   = (phase_q == PHASE_SAMPLE);
  assign nrzi_bit = (line_sync_q == prev_line_q);

  // Receive state machine: all decoding advances only on the sample strobe.
  // Strobes default low so each one is high for exactly one cycle.
  always_comb begin
    state_d     = state_q;
    prev_line_d = prev_line_q;
    ones_d      = ones_q;
    zero_d      = zero_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    err_flag_d  = err_flag_q;
    idle_cnt_d  = idle_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_sop_d    = 1'b0;
    rx_eop_d    = 1'b0;
    rx_err_d    = 1'b0;
    rx_active_d = rx_active_q;

    if (state_q == ST_ERROR) begin
      rx_active_d = 1'b0;
    end

    if (sample) begin
      case (state_q)
        // The NRZI reference is J while idle, so the first K decodes as the
        // first zero of SYNC.
        ST_IDLE: begin
          prev_line_d = LINE_J;
          err_flag_d  = 1'b0;
          if (line_sync_q == LINE_K) begin
            state_d     = ST_SYNC;
            zero_d      = 3'd1;
            prev_line_d = LINE_K;
          end
        end

        // SYNC is a run of zeros closed by a one. Nothing has been announced
        // yet, so a bad SYNC drops silently into ERROR.
        ST_SYNC: begin
          prev_line_d = line_sync_q;
          if ((line_sync_q == LINE_SE0) || (line_sync_q == LINE_SE1)) begin
            state_d    = ST_ERROR;
            idle_cnt_d = '0;
          end else if (!nrzi_bit) begin
            zero_d = (zero_q == 3'd7) ? 3'd7 : zero_q + 3'd1;
          end else if (zero_q >= 3'd3) begin
            state_d     = ST_DATA;
            rx_sop_d    = 1'b1;
            rx_active_d = 1'b1;
            bit_cnt_d   = 3'd0;
            shift_d     = 8'h00;
            ones_d      = 3'd1;
            err_flag_d  = 1'b0;
          end else begin
            state_d    = ST_ERROR;
            idle_cnt_d = '0;
          end
        end

        // The trailing KK of SYNC already counts as one 1 toward stuffing.
        // After six ones the next bit must be a stuff zero.
        ST_DATA: begin
          case (line_sync_q)
            LINE_SE1: begin
              state_d     = ST_ERROR;
              idle_cnt_d  = '0;
              rx_err_d    = 1'b1;
              rx_active_d = 1'b0;
            end
            LINE_SE0: begin
              state_d = ST_EOP;
              if (bit_cnt_q != 3'd0) begin
                rx_err_d    = 1'b1;
                rx_active_d = 1'b0;
                err_flag_d  = 1'b1;
              end
            end
            default: begin
              prev_line_d = line_sync_q;
              if (ones_q == 3'd6) begin
                if (nrzi_bit) begin
                  state_d     = ST_ERROR;
                  idle_cnt_d  = '0;
                  rx_err_d    = 1'b1;
                  rx_active_d = 1'b0;
                end else begin
                  ones_d = 3'd0;
                end
              end else begin
                shift_d = {nrzi_bit, shift_q[7:1]};
                ones_d  = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = {nrzi_bit, shift_q[7:1]};
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = 3'd0;
                end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                end
              end
            end
          endcase
        end

        // SE0 may last arbitrarily long (bus reset). err_flag remembers a
        // truncated byte so the packet never reports both error and EOP.
        ST_EOP: begin
          case (line_sync_q)
            LINE_SE0: begin
              state_d = ST_EOP;
            end
            LINE_J: begin
              state_d     = ST_IDLE;
              prev_line_d = LINE_J;
              rx_active_d = 1'b0;
              if (!err_flag_q) begin
                rx_eop_d = 1'b1;
              end
            end
            default: begin
              state_d     = ST_ERROR;
              idle_cnt_d  = '0;
              rx_active_d = 1'b0;
              if (!err_flag_q) begin
                rx_err_d = 1'b1;
              end
            end
          endcase
        end

        // Wait for an unbroken run of J before trusting the bus again.
        ST_ERROR: begin
          if (line_sync_q == LINE_J) begin
            if (idle_cnt_q == IDLE_LAST) begin
              state_d     = ST_IDLE;
              idle_cnt_d  = '0;
              prev_line_d = LINE_J;
            end else begin
              idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
          end else begin
            idle_cnt_d = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_meta_q <= LINE_J;
      line_sync_q <= LINE_J;
      phase_q     <= '0;
      state_q     <= ST_IDLE;
      prev_line_q <= LINE_J;
      ones_q      <= 3'd0;
      zero_q      <= 3'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      err_flag_q  <= 1'b0;
      idle_cnt_q  <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_sop_q    <= 1'b0;
      rx_eop_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_active_q <= 1'b0;
    end else begin
      line_meta_q <= line_meta_d;
      line_sync_q <= line_sync_d;
      phase_q     <= phase_d;
      state_q     <= state_d;
      prev_line_q <= prev_line_d;
      ones_q      <= ones_d;
      zero_q      <= zero_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      err_flag_q  <= err_flag_d;
      idle_cnt_q  <= idle_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_sop_q    <= rx_sop_d;
      rx_eop_q    <= rx_eop_d;
      rx_err_q    <= rx_err_d;
      rx_active_q <= rx_active_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_sop    = rx_sop_q;
  assign rx_eop    = rx_eop_q;
  assign rx_err    = rx_err_q;
  assign rx_active = rx_active_q;

endmodule
